// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
package axi_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] REG_STEP    = 32'h100;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_id,
  output logic               found
);
  logic [PW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_reg_arbiter.sv
// Round-robin shared register bank: one read-modify-write at a time,
// returning the pre-access value and an OKAY/SLVERR response.
module axi_reg_arbiter
  import axi_arb_pkg::*;
#(
  parameter int                NUM_REQ  = 4,
  parameter int                NUM_REGS = 12,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] REG_BASE = 32'h12345678
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*4-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_we,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);

  state_t                          state;
  logic [IW-1:0]                   last_gnt, id_q;
  logic [3:0]                      addr_q;
  logic [DATA_W-1:0]               wdata_q;
  logic                            we_q;
  logic [NUM_REQ-1:0][3:0]         addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata_v;
  logic [NUM_REQ-1:0]              gnt;
  logic [IW-1:0]                   gnt_id;
  logic                            gnt_any;
  logic                            addr_ok;
  logic [DATA_W-1:0]               regs [NUM_REGS];

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign addr_ok = int'(addr_q) < NUM_REGS;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(IW)) u_arb (
    .req    (req_valid),
    .ptr    (last_gnt),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .found  (gnt_any)
  );

  // Gated by rst so no handshake can complete while the bank is reinitialising.
  assign req_ready = (state == IDLE && rst) ? gnt : '0;
  assign busy      = (state != IDLE);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        regs[g] <= REG_BASE + DATA_W'(REG_STEP * g);
      else if (state == ACCESS && we_q && addr_q == 4'(g))
        regs[g] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= IW'(NUM_REQ - 1);
      id_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          id_q    <= gnt_id;
          addr_q  <= addr_v[gnt_id];
          wdata_q <= wdata_v[gnt_id];
          we_q    <= req_we[gnt_id];
          state   <= ACCESS;
        end
        ACCESS: begin
          if (addr_ok) begin
            rsp_rdata <= regs[addr_q];
            rsp_resp  <= RESP_OKAY;
          end else begin
            rsp_rdata <= '0;
            rsp_resp  <= RESP_SLVERR;
          end
          rsp_valid <= NUM_REQ'(1) << id_q;
          state     <= RESP;
        end
        RESP: if (rsp_ready[id_q]) begin
          rsp_valid <= '0;
          last_gnt  <= id_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
